led_marquee: RTL and testbench
==============================

# led_marquee

Parametrised running-light generator driving the board LED bank. It is the successor to the fixed 8-bit rotating light, generalised in width, initial pattern and step rate. It adds direction control, ping-pong (bounce) and fill/clear modes, synchronous pattern load, a pause input and a step strobe. It sits directly behind the board clock/reset and drives the LED pins, optionally through the top-level output register.

## Interface
- WIDTH, 8, number of LEDs; ≥ 2
- INIT, {WIDTH{1'b0}} | 3'b111 (8'h07 at WIDTH=8), pattern loaded on reset
- DIV, 1, clock cycles per step; ≥ 1 (board build uses 50_000_000)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- en  in  1  1 = run, 0 = pause (prescaler and pattern hold)
- dir  in  1  0 = left (toward MSB), 1 = right (toward LSB)
- mode  in  2  00 ROTATE, 01 BOUNCE, 10 FILL, 11 reserved (= ROTATE)
- load  in  1  synchronous load of `pat`
- pat  in  WIDTH  pattern for `load`
- led  out  WIDTH  current pattern
- step  out  1  one-cycle pulse, high in the cycle a stepped `led` value first appears
- cur_dir  out  1  direction used by the most recent step

## Operation
- Reset (async, any time): led=INIT, step=0, cur_dir=0, prescaler=0, bounce direction bdir=0, fill phase=0.
- Priority per edge: rst > load > tick > hold.
- load: led<=pat, prescaler<=0, bdir<=dir, phase<=0. No step pulse is generated. A tick coinciding with load is discarded.
- Tick: prescaler counts 0..DIV-1 while en=1. Tick is asserted when count==DIV-1 and en=1; the count then wraps to 0. With en=0 the count freezes.
- ROTATE: left gives led<={led[W-2:0],led[W-1]}; right gives led<={led[0],led[W-1:1]}. cur_dir<=dir.
- BOUNCE: logical shifts with zero fill, in direction bdir.
  - If bdir=left and led[W-1]=1, bdir flips to right before the shift. Symmetric rule for bdir=right and led[0]=1.
  - If led[W-1] and led[0] are both 1, led holds and bdir is unchanged.
  - If led==0, led holds.
  - cur_dir<=the direction applied.
- FILL: shift in the direction given by `dir`. In phase 0, 1s are shifted in; in phase 1, 0s are shifted in.
  - At a tick in phase 0 with led all-ones, phase becomes 1 and a 0 is shifted in at that tick.
  - At a tick in phase 1 with led==0, phase becomes 0 and a 1 is shifted in at that tick.
- While mode≠BOUNCE, bdir tracks dir every cycle, so BOUNCE starts in `dir`.
- Mode and dir changes take effect at the next tick. The pattern is never cleared by a mode change.

## Timing
- Step period is DIV cycles of en=1. The first step occurs DIV enabled cycles after reset release or load.
- led, step and cur_dir are all registered. step=1 for exactly one cycle, aligned with the new led value.
- DIV=1 with en=1 gives one step per cycle, with step held high continuously.
- No combinational path from inputs to outputs.

## Configuration
- LED_MARQUEE_FILL_EN defined: FILL mode and the phase register are compiled in.
- LED_MARQUEE_FILL_EN undefined: mode 10 behaves exactly as ROTATE and no phase register exists.

## Structure
- Package led_marquee_pkg holds MODE_ROTATE/MODE_BOUNCE/MODE_FILL (2-bit) and DIR_LEFT/DIR_RIGHT.
- Sub-module led_tick_gen (parameter DIV; ports clk, rst, en, clr, tick) holds the prescaler, sized $clog2(DIV) (min 1 bit). `clr` is driven by load.

## Test plan
- ROTATE, WIDTH=8, DIV=1, dir=0, en=1 after reset: led sequence 07,0E,1C,38,70,E0,C1,83,07; step high each cycle.
- DIV=4: step pulses every 4th cycle. Dropping en for 10 cycles mid-count freezes led and count; the next step arrives after the remaining enabled cycles.
- BOUNCE, load pat=01, dir=0: led 02,04,…,80,40 with cur_dir flipping to 1 at 80→40; sequence continues down to 01,02. Load FF: led holds FF.
- FILL (macro on), load 00, dir=1: 80,C0,…,FF,7F,3F,…,00,80. With macro off, the same stimulus rotates 00 (led stays 00).
- load asserted in the same cycle as a tick: led=pat, no step pulse, next step exactly DIV cycles later.
- rst pulsed asynchronously mid-period and between clock edges: led=07, step=0 immediately; stepping resumes DIV cycles after release.

Source files
------------

// File: rtl/led_marquee_pkg.sv
// Shared definitions for the LED marquee: mode encodings, direction
// encodings and the mode decode used by the top level.
// Optional feature macro: LED_MARQUEE_FILL_EN (enables FILL mode).
package led_marquee_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_FILL   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    localparam logic DIR_LEFT  = 1'b0;   // toward MSB
    localparam logic DIR_RIGHT = 1'b1;   // toward LSB

    // Map the raw mode input onto the behaviour actually implemented:
    // the reserved code runs as ROTATE, and so does FILL when it is not built.
    function automatic mode_e decode_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b01:   r = MODE_BOUNCE;
`ifdef LED_MARQUEE_FILL_EN
            2'b10:   r = MODE_FILL;
`endif
            default: r = MODE_ROTATE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler for the LED marquee. Counts 0..DIV-1 while enabled
// and flags the last count as a tick; freezes while disabled; clr restarts
// the period from zero.
module led_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    // Prescaler: clear wins, otherwise advance and wrap only while enabled.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/led_marquee.sv
// Parametrised running-light generator: ROTATE, BOUNCE and (optionally)
// FILL patterns with direction control, pattern load, pause and a step
// strobe. All outputs are registered.
// Optional feature macro: LED_MARQUEE_FILL_EN (FILL mode and phase register).
module led_marquee
    import led_marquee_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = WIDTH'(3'b111),
    parameter int               DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] pat,
    output logic [WIDTH-1:0] led,
    output logic             step,
    output logic             cur_dir
);

    logic             tick;
    mode_e            eff_mode;
    logic             bdir;
    logic [WIDTH-1:0] nxt_led;
    logic             nxt_bdir;
    logic             nxt_cur_dir;
    logic             bounce_dir;
`ifdef LED_MARQUEE_FILL_EN
    logic             phase;
    logic             nxt_phase;
    logic             fill_bit;
`endif

    led_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    assign eff_mode = decode_mode(mode);

    // Next pattern, bounce direction and applied direction for a tick.
    always_comb begin
        // NOTE: every output of this block gets a default up front so no
        // path through the case leaves a signal unassigned (no latches).
        nxt_led     = led;
        nxt_bdir    = dir;
        nxt_cur_dir = dir;
        bounce_dir  = bdir;
`ifdef LED_MARQUEE_FILL_EN
        nxt_phase   = phase;
        fill_bit    = 1'b0;
`endif
        case (eff_mode)
            MODE_BOUNCE: begin
                nxt_bdir    = bdir;
                nxt_cur_dir = bdir;
                // Empty pattern or lit at both ends: nowhere to move, hold.
                if (led != '0 && !(led[WIDTH-1] && led[0])) begin
                    if (bdir == DIR_LEFT && led[WIDTH-1]) begin
                        bounce_dir = DIR_RIGHT;
                    end else if (bdir == DIR_RIGHT && led[0]) begin
                        bounce_dir = DIR_LEFT;
                    end
                    nxt_led = (bounce_dir == DIR_LEFT) ? {led[WIDTH-2:0], 1'b0}
                                                       : {1'b0, led[WIDTH-1:1]};
                    nxt_bdir    = bounce_dir;
                    nxt_cur_dir = bounce_dir;
                end
            end
`ifdef LED_MARQUEE_FILL_EN
            MODE_FILL: begin
                // Phase flips on the tick that finds the bank full/empty, and
                // that same tick already shifts in the opposite bit.
                if (!phase && led == '1) begin
                    nxt_phase = 1'b1;
                end else if (phase && led == '0) begin
                    nxt_phase = 1'b0;
                end
                fill_bit = ~nxt_phase;
                nxt_led  = (dir == DIR_LEFT) ? {led[WIDTH-2:0], fill_bit}
                                             : {fill_bit, led[WIDTH-1:1]};
            end
`endif
            default: begin
                nxt_led = (dir == DIR_LEFT) ? {led[WIDTH-2:0], led[WIDTH-1]}
                                            : {led[0], led[WIDTH-1:1]};
            end
        endcase
    end

    // Pattern state and registered outputs: rst > load > tick > hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led     <= INIT;
            step    <= 1'b0;
            cur_dir <= 1'b0;
            bdir    <= 1'b0;
`ifdef LED_MARQUEE_FILL_EN
            phase   <= 1'b0;
`endif
        end else if (load) begin
            led     <= pat;
            step    <= 1'b0;
            bdir    <= dir;
`ifdef LED_MARQUEE_FILL_EN
            phase   <= 1'b0;
`endif
        end else if (tick) begin
            led     <= nxt_led;
            step    <= 1'b1;
            cur_dir <= nxt_cur_dir;
            bdir    <= nxt_bdir;
`ifdef LED_MARQUEE_FILL_EN
            phase   <= nxt_phase;
`endif
        end else begin
            step <= 1'b0;
            // Outside BOUNCE the bounce direction follows dir, so a later
            // switch into BOUNCE starts moving in the requested direction.
            if (eff_mode != MODE_BOUNCE) begin
                bdir <= dir;
            end
        end
    end

endmodule

// File: tb/tb_led_marquee.sv
// Self-checking bench for led_marquee: a DIV=1 and a DIV=4 instance share
// stimulus; both are compared every cycle against a behavioural model, plus
// table-driven sequences and hand-written multi-cycle corner cases.
module tb_led_marquee;

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [7:0] pat;
    logic [7:0] led1, led4;
    logic       step1, step4;
    logic       cd1, cd4;

    int n_pass;
    int n_total;

    led_marquee #(.WIDTH(8), .INIT(8'h07), .DIV(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .pat(pat), .led(led1), .step(step1), .cur_dir(cd1)
    );

    led_marquee #(.WIDTH(8), .INIT(8'h07), .DIV(4)) u4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .pat(pat), .led(led4), .step(step4), .cur_dir(cd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: pattern as an integer 0..255.
    typedef struct {
        int led;
        bit step;
        bit cd;
        bit bdir;
        bit phase;
        int cnt;
    } mstate_t;

    mstate_t m1, m4;

    typedef struct {
        bit         en;
        bit         dir;
        logic [1:0] mode;
        bit         load;
        logic [7:0] pat;
        logic [7:0] exp_led;
        bit         exp_step;
        bit         exp_cd;
    } vec_t;

    vec_t vecs[$];

    function automatic mstate_t model_reset();
        mstate_t s;
        s.led = 7; s.step = 0; s.cd = 0; s.bdir = 0; s.phase = 0; s.cnt = 0;
        return s;
    endfunction

    function automatic mstate_t model_next(mstate_t s, int div, bit e, bit d,
                                           int md, bit ld, int p);
        mstate_t n = s;
        bit      tk;
        int      v;
        int      b;
        bit      top;
        bit      bot;
        bit      bd;
        if (ld) begin
            n.led = p; n.cnt = 0; n.bdir = d; n.phase = 0; n.step = 0;
            return n;
        end
        tk = e && (s.cnt == div - 1);
        if (e) n.cnt = (s.cnt + 1) % div;
        if (!tk) begin
            n.step = 0;
            if (md != 1) n.bdir = d;
            return n;
        end
        n.step = 1;
        if (md == 3) md = 0;
`ifndef LED_MARQUEE_FILL_EN
        if (md == 2) md = 0;
`endif
        v = s.led;
        if (md == 1) begin
            top = (v >= 128);
            bot = (v % 2 == 1);
            n.cd = s.bdir;
            if (v != 0 && !(top && bot)) begin
                bd = s.bdir;
                if (!bd && top) bd = 1;
                else if (bd && bot) bd = 0;
                n.led = bd ? v / 2 : (v * 2) % 256;
                n.bdir = bd;
                n.cd = bd;
            end
        end else if (md == 2) begin
            if (!s.phase && v == 255) n.phase = 1;
            else if (s.phase && v == 0) n.phase = 0;
            b = n.phase ? 0 : 1;
            n.led = d ? (v / 2 + b * 128) : ((v * 2) % 256 + b);
            n.cd = d;
            n.bdir = d;
        end else begin
            n.led = d ? (v / 2 + (v % 2) * 128) : ((v * 2) % 256 + v / 128);
            n.cd = d;
            n.bdir = d;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock: drive inputs, advance models at the edge, compare at negedge.
    task automatic run(input bit e, input bit d, input logic [1:0] md,
                       input bit ld, input logic [7:0] p);
        en = e; dir = d; mode = md; load = ld; pat = p;
        @(posedge clk);
        m1 = model_next(m1, 1, e, d, int'(md), ld, int'(p));
        m4 = model_next(m4, 4, e, d, int'(md), ld, int'(p));
        @(negedge clk);
        check("u1.led",  32'(led1),  32'(m1.led));
        check("u1.step", 32'(step1), 32'(m1.step));
        check("u1.dir",  32'(cd1),   32'(m1.cd));
        check("u4.led",  32'(led4),  32'(m4.led));
        check("u4.step", 32'(step4), 32'(m4.step));
        check("u4.dir",  32'(cd4),   32'(m4.cd));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst.led1",  32'(led1),  32'h07);
        check("rst.step1", 32'(step1), 32'h0);
        check("rst.dir1",  32'(cd1),   32'h0);
        check("rst.led4",  32'(led4),  32'h07);
        check("rst.step4", 32'(step4), 32'h0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        m1 = model_reset();
        m4 = model_reset();
    endtask

    task automatic add(input bit e, input bit d, input logic [1:0] md,
                       input bit ld, input logic [7:0] p, input logic [7:0] el,
                       input bit es, input bit ec);
        vec_t v;
        v.en = e; v.dir = d; v.mode = md; v.load = ld; v.pat = p;
        v.exp_led = el; v.exp_step = es; v.exp_cd = ec;
        vecs.push_back(v);
    endtask

    logic [7:0] rot_exp  [8]  = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'hC1, 8'h83, 8'h07};
    logic [7:0] bnc_exp  [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
`ifdef LED_MARQUEE_FILL_EN
    logic [7:0] fill_exp [17] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                                  8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
`else
    logic [7:0] fill_exp [17] = '{default: 8'h00};
`endif

    initial begin
        bit         rd;
        logic [1:0] rm;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 2'b00; load = 1'b0; pat = 8'h00;
        m1 = model_reset();
        m4 = model_reset();
        #3;
        check("init.led1",  32'(led1),  32'h07);
        check("init.step1", 32'(step1), 32'h0);
        check("init.dir1",  32'(cd1),   32'h0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Table: ROTATE left, BOUNCE from 01, BOUNCE on FF, FILL right from 00.
        for (int i = 0; i < 8; i++) add(1, 0, 2'b00, 0, 8'h00, rot_exp[i], 1, 0);
        add(1, 0, 2'b01, 1, 8'h01, 8'h01, 0, 0);
        for (int i = 0; i < 15; i++) add(1, 0, 2'b01, 0, 8'h00, bnc_exp[i], 1, (i >= 7 && i < 14));
        add(1, 0, 2'b01, 1, 8'hFF, 8'hFF, 0, 0);
        add(1, 0, 2'b01, 0, 8'h00, 8'hFF, 1, 0);
        add(1, 0, 2'b01, 0, 8'h00, 8'hFF, 1, 0);
        add(1, 1, 2'b10, 1, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 17; i++) add(1, 1, 2'b10, 0, 8'h00, fill_exp[i], 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            run(vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].pat);
            check($sformatf("vec%0d.led", i),  32'(led1),  32'(vecs[i].exp_led));
            check($sformatf("vec%0d.step", i), 32'(step1), 32'(vecs[i].exp_step));
            check($sformatf("vec%0d.dir", i),  32'(cd1),   32'(vecs[i].exp_cd));
        end

        // DIV=4: a step every 4th enabled cycle.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            run(1, 0, 2'b00, 0, 8'h00);
            check("div4.step", 32'(step4), 32'(k % 4 == 0));
            check("div4.led",  32'(led4),  (k < 4) ? 32'h07 : (k < 8) ? 32'h0E : 32'h1C);
        end
        run(1, 0, 2'b00, 0, 8'h00);
        run(1, 0, 2'b00, 0, 8'h00);
        // Pause mid-count: pattern and prescaler freeze.
        for (int k = 0; k < 10; k++) begin
            run(0, 0, 2'b00, 0, 8'h00);
            check("pause.led",  32'(led4),  32'h1C);
            check("pause.step", 32'(step4), 32'h0);
        end
        run(1, 0, 2'b00, 0, 8'h00);
        check("resume.nostep", 32'(step4), 32'h0);
        run(1, 0, 2'b00, 0, 8'h00);
        check("resume.step", 32'(step4), 32'h1);
        check("resume.led",  32'(led4),  32'h38);

        // Load in the same cycle as a tick: no step, next step DIV cycles later.
        for (int k = 0; k < 3; k++) run(1, 0, 2'b00, 0, 8'h00);
        run(1, 0, 2'b00, 1, 8'hA5);
        check("ldtick.led",  32'(led4),  32'hA5);
        check("ldtick.step", 32'(step4), 32'h0);
        for (int k = 0; k < 3; k++) begin
            run(1, 0, 2'b00, 0, 8'h00);
            check("ldtick.wait", 32'(step4), 32'h0);
        end
        run(1, 0, 2'b00, 0, 8'h00);
        check("ldtick.step2", 32'(step4), 32'h1);
        check("ldtick.led2",  32'(led4),  32'h4B);

        // Asynchronous reset mid-period, then restart DIV cycles after release.
        run(1, 0, 2'b00, 0, 8'h00);
        run(1, 0, 2'b00, 0, 8'h00);
        do_reset();
        for (int k = 1; k <= 4; k++) run(1, 0, 2'b00, 0, 8'h00);
        check("rstmid.step", 32'(step4), 32'h1);
        check("rstmid.led",  32'(led4),  32'h0E);

        // Randomised run against the model.
        rd = 1'b0;
        rm = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) rd = ~rd;
            if ($urandom_range(0, 30) == 0) rm = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 300) == 0) do_reset();
            run($urandom_range(0, 4) != 0, rd, rm, $urandom_range(0, 24) == 0,
                8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
